// File: rtl/gru_gate_mac_responder.sv
// Sequential GRU gate engine: one MAC per cycle over x_t and h_t_prev, bias add,
// saturating rescale and a selectable piecewise-linear activation.
module gru_gate_mac_responder #(
  parameter int unsigned D          = 64,
  parameter int unsigned H          = 16,
  parameter int unsigned DATA_WIDTH = 15,
  parameter int unsigned FRAC_BITS  = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [1:0]                   act_sel,
  input  logic signed [DATA_WIDTH-1:0] x_t      [D],
  input  logic signed [DATA_WIDTH-1:0] h_t_prev [H],
  input  logic signed [DATA_WIDTH-1:0] w_x_row  [D],
  input  logic signed [DATA_WIDTH-1:0] w_h_row  [H],
  input  logic signed [DATA_WIDTH-1:0] b_x,
  input  logic signed [DATA_WIDTH-1:0] b_h,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         valid_out,
  output logic                         busy
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned ACC_W  = 2 * DW + $clog2(D + H + 2) + 1;
  localparam int unsigned XIDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned HIDX_W = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned IDX_W  = (XIDX_W > HIDX_W) ? XIDX_W : HIDX_W;
  localparam int unsigned ONE    = 2 ** FRAC_BITS;

  localparam logic signed [ACC_W-1:0] ACC_SMAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_SMIN = ~ACC_SMAX;
  localparam logic signed [DW-1:0]    ONE_D    = DW'(ONE);
  localparam logic signed [DW-1:0]    NEG_ONE_D = -ONE_D;
  localparam logic signed [DW:0]      ONE_W    = (DW + 1)'(ONE);
  localparam logic signed [DW:0]      HALF_W   = (DW + 1)'(ONE / 2);

  typedef enum logic [2:0] {IDLE, MAC_X, MAC_H, BIAS, ACT, DONE} state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [IDX_W-1:0]         idx, idx_next;
  logic signed [DW-1:0]     result_next;
  logic                     valid_out_next;

  logic signed [PROD_W-1:0] prod_x, prod_h;
  logic signed [DW:0]       bias_sum;
  logic signed [ACC_W-1:0]  bias_term, shifted;
  logic signed [DW-1:0]     sat_s, act_val;
  logic signed [DW:0]       sig_raw;

  // Full-precision products for the current element and the aligned bias term
  always_comb begin
    prod_x    = PROD_W'(x_t[idx[XIDX_W-1:0]]) * PROD_W'(w_x_row[idx[XIDX_W-1:0]]);
    prod_h    = PROD_W'(h_t_prev[idx[HIDX_W-1:0]]) * PROD_W'(w_h_row[idx[HIDX_W-1:0]]);
    bias_sum  = (DW + 1)'(b_x) + (DW + 1)'(b_h);
    bias_term = ACC_W'(bias_sum) <<< FRAC_BITS;
  end

  // Rescale with floor shift, saturate to the word range, then activate
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > ACC_SMAX)      sat_s = DW'(ACC_SMAX);
    else if (shifted < ACC_SMIN) sat_s = DW'(ACC_SMIN);
    else                         sat_s = DW'(shifted);

    sig_raw = (DW + 1)'(sat_s >>> 2) + HALF_W;
    act_val = sat_s;
    case (act_sel)
      2'd0: begin
        if (sig_raw[DW])          act_val = '0;
        else if (sig_raw > ONE_W) act_val = ONE_D;
        else                      act_val = DW'(sig_raw);
      end
      2'd1: begin
        if (sat_s > ONE_D)          act_val = ONE_D;
        else if (sat_s < NEG_ONE_D) act_val = NEG_ONE_D;
        else                        act_val = sat_s;
      end
      default: act_val = sat_s;
    endcase
  end

  // Next-state and datapath updates; any drop of valid_in before DONE aborts
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    idx_next       = idx;
    result_next    = result;
    valid_out_next = valid_out;
    case (state)
      IDLE: begin
        valid_out_next = 1'b0;
        if (valid_in) begin
          acc_next   = '0;
          idx_next   = '0;
          state_next = MAC_X;
        end
      end
      MAC_X: begin
        if (!valid_in) begin
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          acc_next = acc + ACC_W'(prod_x);
          if (idx == IDX_W'(D - 1)) begin
            idx_next   = '0;
            state_next = MAC_H;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      MAC_H: begin
        if (!valid_in) begin
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          acc_next = acc + ACC_W'(prod_h);
          if (idx == IDX_W'(H - 1)) begin
            idx_next   = '0;
            state_next = BIAS;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      BIAS: begin
        if (!valid_in) state_next = IDLE;
        else begin
          acc_next   = acc + bias_term;
          state_next = ACT;
        end
      end
      ACT: begin
        if (!valid_in) state_next = IDLE;
        else begin
          result_next    = act_val;
          valid_out_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (!valid_in) begin
          valid_out_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        valid_out_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      result    <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      idx       <= idx_next;
      result    <= result_next;
      valid_out <= valid_out_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/gru_gate_mac_responder.md
Name: gru_gate_mac_responder

Overview:
- Per-element gate compute engine on the responder side of the GRU controller's level-held valid_in/valid_out handshake.
- Computes one gate pre-activation sequentially, applies a selectable piecewise-linear activation, and presents the result to the controller: act(W_x_row·x_t + W_h_row·h_prev + b_x + b_h).
- One MAC per cycle. Instantiated NUM_PARALLEL times under a batch controller.

Parameters:
D, 64, input vector length
H, 16, hidden vector length
DATA_WIDTH, 15, signed fixed-point word width
FRAC_BITS, 9, fractional bits (1.0 = 2^FRAC_BITS = 512)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  request; held high by the controller until it has consumed the result
act_sel  in  2  0 = hard sigmoid, 1 = hard tanh, 2/3 = linear (saturate only)
x_t  in  D x DATA_WIDTH signed  input vector
h_t_prev  in  H x DATA_WIDTH signed  previous hidden state
w_x_row  in  D x DATA_WIDTH signed  input weight row
w_h_row  in  H x DATA_WIDTH signed  hidden weight row
b_x  in  DATA_WIDTH signed  input bias
b_h  in  DATA_WIDTH signed  hidden bias
result  out  DATA_WIDTH signed  gate output, registered
valid_out  out  1  result valid; held until valid_in falls
busy  out  1  high in every state except IDLE

Behaviour:
- One clock domain; reset is synchronous and active-high.
- On reset: state IDLE, result = 0, valid_out = 0, busy = 0, accumulator = 0, index = 0. Reset mid-operation aborts immediately with these same values.
- Inputs must stay stable while valid_in is high. The block does not latch the vectors.
- FSM states and transitions:
  - IDLE: on valid_in = 1, clear the accumulator and go to MAC_X.
  - MAC_X: acc += x_t[k]*w_x_row[k] for k = 0..D-1, one term per cycle (D cycles), then go to MAC_H.
  - MAC_H: acc += h_t_prev[k]*w_h_row[k] for k = 0..H-1 (H cycles), then go to BIAS.
  - BIAS: acc += (b_x + b_h) << FRAC_BITS, then go to ACT.
  - ACT: compute s = sat(acc >>> FRAC_BITS), apply the activation, register result, set valid_out = 1, go to DONE.
  - DONE: hold result and valid_out while valid_in = 1. When valid_in = 0, go to IDLE and clear valid_out on that same edge; result keeps its value.
- Latency: valid_out is high exactly D+H+2 edges after the edge where IDLE sampled valid_in = 1.
- Abort: if valid_in = 0 in MAC_X, MAC_H, BIAS or ACT, go to IDLE on that edge. valid_out stays 0 and result is unchanged.
- Back-to-back requests: the earliest new sample is the edge after DONE→IDLE. This needs valid_in low for at least one cycle.
- Arithmetic:
  - Accumulator width is 2*DATA_WIDTH + clog2(D+H+2) + 1, signed; it never overflows.
  - Products are full-precision Q(2*FRAC_BITS).
  - The final shift is arithmetic (floor toward -inf).
  - sat() clamps to [-2^(DW-1), 2^(DW-1)-1] = [-16384, 16383].
- Activations (ONE = 2^FRAC_BITS):
  - Hard sigmoid: y = clamp((s >>> 2) + ONE/2, 0, ONE). s = 0 → 256; s ≥ 1024 → 512; s ≤ -1024 → 0.
  - Hard tanh: y = clamp(s, -ONE, ONE).
  - Linear: y = s.
- act_sel is sampled in ACT only.

Test Plan:
- All weights and biases 0, act_sel = 0, valid_in held → valid_out rises at edge 82 (D = 64, H = 16); result = 256; the value holds while valid_in stays high.
- x_t[0] = 512, w_x_row[0] = 256, all else 0, act_sel = 1 → 256; repeat with act_sel = 0 → 320; with act_sel = 2 → 256.
- x_t all 512, w_x_row all 512, act_sel = 2 → result = 16383 (saturated). Same with w_x_row all -512 → -16384. act_sel = 1 → -512.
- x_t[0] = 1, w_x_row[0] = -1, all else 0, act_sel = 2 → result = -1 (floor shift). b_x = 100, b_h = -30 → result = 69.
- valid_in dropped at edge 40 → busy falls on the next edge, valid_out never asserts, result keeps its prior value. Re-raising valid_in starts a full-latency run.
- rst pulsed mid-MAC_H and again in DONE → the next edge shows result = 0, valid_out = 0, busy = 0. After rst releases with valid_in high, a fresh computation starts.
